// File: rtl/memory_access_pkg.sv
// Memory-access stage types: FSM state encoding and set-less-than funct3 helpers.
package ma_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ma_state_t;

    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;

    function automatic logic is_set_less_than(input logic [2:0] funct3);
        return (funct3 == FUNCT3_SLT) || (funct3 == FUNCT3_SLTU);
    endfunction

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I types: opcodes, load funct3 encodings and the pipeline control word.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  aluop;
        logic        load_regfile;
        logic        mem_read;
        logic        mem_write;
    } rv32i_control_word;

endpackage

// File: rtl/memory_access_load_align.sv
// Combinational load extraction: shifts the addressed bytes down and sign/zero-extends them.
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // NOTE: data is assigned on every path (default arm included) so no latch is inferred.
    always_comb begin
        case (load_funct3_t'(funct3))
            lb:      data = {{24{shifted[7]}}, shifted[7:0]};
            lbu:     data = {24'b0, shifted[7:0]};
            lh:      data = {{16{shifted[15]}}, shifted[15:0]};
            lhu:     data = {16'b0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MA pipeline stage: data-memory handshake, store alignment, load extraction, MA/WB register.
// Optional build macro MA_PERF_CNT_EN adds stall-cycle and memory-op counters.
module memory_access
    import rv32i_types::*;
    import ma_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  rv32i_control_word ctrl_word_in,
    input  logic [31:0]       instruction_in,
    input  logic [31:0]       PC_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       rs2_in,
    input  logic              br_en_in,
    input  logic [3:0]        mem_byte_enable_in,
    input  logic              IF_stall,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [31:0]       dmem_address,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_mbe,
    output logic              MA_stall,
    output rv32i_control_word ctrl_word_out,
    output logic [31:0]       instruction_out,
    output logic [31:0]       PC_out,
    output logic [31:0]       alu_out,
    output logic              br_en_out,
    output logic [31:0]       wb_data_out
`ifdef MA_PERF_CNT_EN
    ,
    output logic [31:0]       ma_stall_cycles,
    output logic [31:0]       ma_mem_ops
`endif
);

    ma_state_t   state, state_next;
    logic        mem_op;
    logic        advance;
    logic        use_buf;
    logic        buf_load;
    logic [2:0]  funct3;
    logic [31:0] load_buf;
    logic [31:0] load_src;
    logic [31:0] load_data;
    logic [31:0] wb_data;

    assign funct3       = instruction_in[14:12];
    assign mem_op       = ctrl_word_in.mem_read | ctrl_word_in.mem_write;
    assign advance      = !MA_stall && !IF_stall;

    assign dmem_address = {alu_in[31:2], 2'b00};
    assign dmem_mbe     = mem_byte_enable_in;
    assign dmem_wdata   = rs2_in << {alu_in[1:0], 3'b000};

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            load_buf <= '0;
        end else begin
            state <= state_next;
            if (buf_load) begin
                load_buf <= dmem_rdata;
            end
        end
    end

    // HOLD parks a completed load whose result cannot leave yet because fetch is stalled.
    always_comb begin
        state_next = state;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        MA_stall   = 1'b0;
        use_buf    = 1'b0;
        buf_load   = 1'b0;
        unique case (state)
            IDLE, WAIT: begin
                dmem_read  = ctrl_word_in.mem_read;
                dmem_write = ctrl_word_in.mem_write;
                MA_stall   = mem_op && !dmem_resp;
                if (!mem_op) begin
                    state_next = IDLE;
                end else if (!dmem_resp) begin
                    state_next = WAIT;
                end else if (IF_stall) begin
                    state_next = HOLD;
                    buf_load   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                use_buf = 1'b1;
                if (!IF_stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign load_src = use_buf ? load_buf : dmem_rdata;

    load_align u_load_align (
        .rdata  (load_src),
        .offset (alu_in[1:0]),
        .funct3 (funct3),
        .data   (load_data)
    );

    always_comb begin
        if (ctrl_word_in.opcode == op_load) begin
            wb_data = load_data;
        end else if (ctrl_word_in.opcode == op_jal || ctrl_word_in.opcode == op_jalr) begin
            wb_data = PC_in + 32'd4;
        end else if ((ctrl_word_in.opcode == op_imm || ctrl_word_in.opcode == op_reg)
                     && is_set_less_than(funct3)) begin
            wb_data = {31'b0, br_en_in};
        end else begin
            wb_data = alu_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_word_out   <= '0;
            instruction_out <= '0;
            PC_out          <= '0;
            alu_out         <= '0;
            br_en_out       <= 1'b0;
            wb_data_out     <= '0;
        end else if (advance) begin
            ctrl_word_out   <= ctrl_word_in;
            instruction_out <= instruction_in;
            PC_out          <= PC_in;
            alu_out         <= alu_in;
            br_en_out       <= br_en_in;
            wb_data_out     <= wb_data;
        end
    end

`ifdef MA_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ma_stall_cycles <= '0;
            ma_mem_ops      <= '0;
        end else begin
            if (MA_stall) begin
                ma_stall_cycles <= ma_stall_cycles + 32'd1;
            end
            if (state != HOLD && mem_op && dmem_resp) begin
                ma_mem_ops <= ma_mem_ops + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: expected writeback results are queued at drive time
// and compared when the MA/WB register advances.
module tb_memory_access;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    rv32i_control_word ctrl_word_in;
    logic [31:0]       instruction_in;
    logic [31:0]       PC_in;
    logic [31:0]       alu_in;
    logic [31:0]       rs2_in;
    logic              br_en_in;
    logic [3:0]        mem_byte_enable_in;
    logic              IF_stall;
    logic [31:0]       dmem_rdata;
    logic              dmem_resp;
    logic              dmem_read;
    logic              dmem_write;
    logic [31:0]       dmem_address;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_mbe;
    logic              MA_stall;
    rv32i_control_word ctrl_word_out;
    logic [31:0]       instruction_out;
    logic [31:0]       PC_out;
    logic [31:0]       alu_out;
    logic              br_en_out;
    logic [31:0]       wb_data_out;
`ifdef MA_PERF_CNT_EN
    logic [31:0]       ma_stall_cycles;
    logic [31:0]       ma_mem_ops;
`endif

    typedef struct {
        string       tag;
        logic [31:0] wb;
        logic [31:0] pc;
    } exp_t;

    exp_t scoreboard[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    memory_access dut (
        .clk                (clk),
        .rst                (rst),
        .ctrl_word_in       (ctrl_word_in),
        .instruction_in     (instruction_in),
        .PC_in              (PC_in),
        .alu_in             (alu_in),
        .rs2_in             (rs2_in),
        .br_en_in           (br_en_in),
        .mem_byte_enable_in (mem_byte_enable_in),
        .IF_stall           (IF_stall),
        .dmem_rdata         (dmem_rdata),
        .dmem_resp          (dmem_resp),
        .dmem_read          (dmem_read),
        .dmem_write         (dmem_write),
        .dmem_address       (dmem_address),
        .dmem_wdata         (dmem_wdata),
        .dmem_mbe           (dmem_mbe),
        .MA_stall           (MA_stall),
        .ctrl_word_out      (ctrl_word_out),
        .instruction_out    (instruction_out),
        .PC_out             (PC_out),
        .alu_out            (alu_out),
        .br_en_out          (br_en_out),
        .wb_data_out        (wb_data_out)
`ifdef MA_PERF_CNT_EN
        ,
        .ma_stall_cycles    (ma_stall_cycles),
        .ma_mem_ops         (ma_mem_ops)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic rv32i_control_word mk_ctrl(input rv32i_opcode opc);
        rv32i_control_word c;
        c              = '0;
        c.opcode       = opc;
        c.mem_read     = (opc == op_load);
        c.mem_write    = (opc == op_store);
        c.load_regfile = (opc != op_store) && (opc != op_br);
        return c;
    endfunction

    // Drive one instruction into the EX/MA inputs and queue its expected writeback value.
    task automatic drive(input string tag, input rv32i_opcode opc, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic br, input logic [3:0] mbe, input logic [31:0] exp_wb);
        exp_t e;
        ctrl_word_in       = mk_ctrl(opc);
        instruction_in     = {17'b0, f3, 5'd1, opc};
        PC_in              = pc;
        alu_in             = alu;
        rs2_in             = rs2;
        br_en_in           = br;
        mem_byte_enable_in = mbe;
        e.tag = tag;
        e.wb  = exp_wb;
        e.pc  = pc;
        scoreboard.push_back(e);
    endtask

    task automatic bubble(input string tag, input logic [31:0] pc);
        exp_t e;
        ctrl_word_in       = '0;
        instruction_in     = '0;
        PC_in              = pc;
        alu_in             = '0;
        rs2_in             = '0;
        br_en_in           = 1'b0;
        mem_byte_enable_in = '0;
        e.tag = tag;
        e.wb  = 32'h0;
        e.pc  = pc;
        scoreboard.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (scoreboard.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty: observed=output expected=no_output");
        end else begin
            e = scoreboard.pop_front();
            check({e.tag, "_wb"}, wb_data_out, e.wb);
            check({e.tag, "_pc"}, PC_out, e.pc);
        end
    endtask

    // Non-memory instruction: no stall, no request, result one edge later.
    task automatic run_alu(input string tag);
        #1;
        check({tag, "_stall"}, {31'b0, MA_stall}, 32'h0);
        check({tag, "_req"}, {30'b0, dmem_read, dmem_write}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        pop_check();
    endtask

    // Memory instruction: resp arrives n_lat cycles after the request; if hold>0, IF_stall
    // is high on the resp cycle and for hold-1 further cycles.
    task automatic run_mem(input string tag, input int n_lat, input logic [31:0] rdata,
                           input int hold, input int exp_stalls);
        int stalls = 0;
        for (int c = 0; c <= n_lat; c++) begin
            dmem_resp  = (c == n_lat);
            dmem_rdata = (c == n_lat) ? rdata : 32'hDEADBEEF;
            IF_stall   = (c == n_lat) && (hold > 0);
            #1;
            if (MA_stall) stalls++;
            @(posedge clk);
            @(negedge clk);
        end
        dmem_resp  = 1'b0;
        dmem_rdata = 32'hDEADBEEF;
        IF_stall   = 1'b0;
        check({tag, "_stall_cycles"}, stalls, exp_stalls);
        if (hold > 0) begin
            for (int h = 1; h < hold; h++) begin
                IF_stall   = 1'b1;
                dmem_resp  = 1'b1;
                dmem_rdata = 32'h5A5A5A5A;
                #1;
                check({tag, "_hold_req"}, {30'b0, dmem_read, dmem_write}, 32'h0);
                check({tag, "_hold_stall"}, {31'b0, MA_stall}, 32'h0);
                @(posedge clk);
                @(negedge clk);
            end
            IF_stall   = 1'b0;
            dmem_resp  = 1'b0;
            dmem_rdata = 32'hDEADBEEF;
            #1;
            check({tag, "_release_req"}, {30'b0, dmem_read, dmem_write}, 32'h0);
            @(posedge clk);
            @(negedge clk);
        end
        pop_check();
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        IF_stall   = 1'b0;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'hDEADBEEF;
        ctrl_word_in       = '0;
        instruction_in     = '0;
        PC_in              = '0;
        alu_in             = '0;
        rs2_in             = '0;
        br_en_in           = 1'b0;
        mem_byte_enable_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_wb", wb_data_out, 32'h0);
        check("reset_pc", PC_out, 32'h0);
        check("reset_ctrl", {18'b0, ctrl_word_out}, 32'h0);
        check("reset_stall", {31'b0, MA_stall}, 32'h0);

        // lb at byte 3, resp after 2 cycles
        drive("lb_off3", op_load, lb, 32'h100, 32'h1003, 32'h0, 1'b0, 4'b1000, 32'hFFFFFF80);
        #1;
        check("lb_addr", dmem_address, 32'h1000);
        check("lb_req", {30'b0, dmem_read, dmem_write}, 32'h2);
        run_mem("lb_off3", 2, 32'h80112233, 0, 2);

        // sh at halfword 1
        drive("sh", op_store, 3'b001, 32'h104, 32'h2002, 32'h0000ABCD, 1'b0, 4'b1100, 32'h2002);
        #1;
        check("sh_req", {30'b0, dmem_read, dmem_write}, 32'h1);
        check("sh_wdata", dmem_wdata, 32'hABCD0000);
        check("sh_mbe", {28'b0, dmem_mbe}, 32'hC);
        check("sh_addr", dmem_address, 32'h2000);
        run_mem("sh", 1, 32'h0, 0, 1);

        // lhu completing while fetch is stalled for 3 cycles
        drive("lhu_hold", op_load, lhu, 32'h108, 32'h3002, 32'h0, 1'b0, 4'b1100, 32'h00009ABC);
        run_mem("lhu_hold", 1, 32'h9ABC0000, 3, 1);

        drive("jal", op_jal, 3'b000, 32'h40, 32'h0000_0080, 32'h0, 1'b0, 4'b0000, 32'h44);
        run_alu("jal");
        drive("slti", op_imm, 3'b010, 32'h44, 32'h0000_0123, 32'h0, 1'b1, 4'b0000, 32'h1);
        run_alu("slti");
        drive("sltu", op_reg, 3'b011, 32'h48, 32'h0000_0456, 32'h0, 1'b0, 4'b0000, 32'h0);
        run_alu("sltu");
        drive("add", op_reg, 3'b000, 32'h4C, 32'h0000_1234, 32'h0, 1'b1, 4'b0000, 32'h1234);
        run_alu("add");
        drive("jalr", op_jalr, 3'b000, 32'h50, 32'h0000_0200, 32'h0, 1'b0, 4'b0000, 32'h54);
        run_alu("jalr");

        // response in the request cycle: no stall
        drive("lw_fast", op_load, lw, 32'h54, 32'h0100, 32'h0, 1'b0, 4'b1111, 32'hCAFEF00D);
        run_mem("lw_fast", 0, 32'hCAFEF00D, 0, 0);
        drive("lh_neg", op_load, lh, 32'h58, 32'h4002, 32'h0, 1'b0, 4'b1100, 32'hFFFF8000);
        run_mem("lh_neg", 1, 32'h80000000, 0, 1);
        drive("lb_pos", op_load, lb, 32'h5C, 32'h4000, 32'h0, 1'b0, 4'b0001, 32'h0000007F);
        run_mem("lb_pos", 1, 32'h1234567F, 0, 1);
        drive("lbu_off1", op_load, lbu, 32'h60, 32'h4001, 32'h0, 1'b0, 4'b0010, 32'h000000F0);
        run_mem("lbu_off1", 1, 32'h0000F000, 0, 1);

        // bubble with a stray response in IDLE
        bubble("bubble", 32'h64);
        dmem_resp = 1'b1;
        run_alu("bubble");
        dmem_resp = 1'b0;

        drive("lw_mis", op_load, lw, 32'h68, 32'h5001, 32'h0, 1'b0, 4'b1111, 32'h00112233);
        run_mem("lw_mis", 1, 32'h11223344, 0, 1);

        // reset while waiting on a load; upstream EX/MA resets to a bubble alongside
        drive("rst_victim", op_load, lw, 32'h6C, 32'h6000, 32'h0, 1'b0, 4'b1111, 32'h0);
        void'(scoreboard.pop_back());
        #1;
        check("wait_stall", {31'b0, MA_stall}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bubble("rst_bubble", 32'h0);
        void'(scoreboard.pop_back());
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_wb", wb_data_out, 32'h0);
        check("rst_pc", PC_out, 32'h0);
        check("rst_alu", alu_out, 32'h0);
        check("rst_instr", instruction_out, 32'h0);
        check("rst_req", {30'b0, dmem_read, dmem_write}, 32'h0);
        check("rst_stall", {31'b0, MA_stall}, 32'h0);
`ifdef MA_PERF_CNT_EN
        check("rst_perf_stall", ma_stall_cycles, 32'h0);
        check("rst_perf_ops", ma_mem_ops, 32'h0);
`endif

        bubble("stray_resp", 32'h70);
        dmem_resp = 1'b1;
        run_alu("stray_resp");
        dmem_resp = 1'b0;

        // two loads with a 3-cycle latency each; FSM must have returned to IDLE
        drive("perf_ld0", op_load, lw, 32'h74, 32'h7000, 32'h0, 1'b0, 4'b1111, 32'h01020304);
        run_mem("perf_ld0", 2, 32'h01020304, 0, 2);
        drive("perf_ld1", op_load, lbu, 32'h78, 32'h7002, 32'h0, 1'b0, 4'b0100, 32'h000000AB);
        run_mem("perf_ld1", 2, 32'h00AB0000, 0, 2);
`ifdef MA_PERF_CNT_EN
        check("perf_stall_cycles", ma_stall_cycles, 32'd4);
        check("perf_mem_ops", ma_mem_ops, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline stage directly downstream of the execute stage; consumes its EX/MA register (ctrl word, instruction, PC, ALU result, forwarded rs2, br_en, byte enables).
- Drives the data-memory handshake, aligns store data, and extracts/sign-extends load data.
- Raises MA_stall while an access is outstanding.
- Registers results into the MA/WB register; that register also feeds execute forwarding (mem_wb, mem_wb_data).

Parameters:
- none (widths fixed by rv32i_types: 32-bit data/address, 4-bit byte enable)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ctrl_word_in  in  rv32i_control_word  EX/MA control (uses opcode, mem_read, mem_write)
instruction_in  in  32  EX/MA instruction
PC_in  in  32  EX/MA PC
alu_in  in  32  EX/MA ALU result / effective address
rs2_in  in  32  forwarded store data
br_en_in  in  1  compare result
mem_byte_enable_in  in  4  byte enables computed in EX
IF_stall  in  1  fetch-side stall
dmem_rdata  in  32  data memory read data
dmem_resp  in  1  data memory response, 1-cycle pulse
dmem_read  out  1  read request
dmem_write  out  1  write request
dmem_address  out  32  word-aligned address
dmem_wdata  out  32  byte-lane-aligned store data
dmem_mbe  out  4  byte enable to memory
MA_stall  out  1  stage busy
ctrl_word_out  out  rv32i_control_word  MA/WB control (to WB and EX forwarding)
instruction_out, PC_out, alu_out  out  32 each  MA/WB copies
br_en_out  out  1  MA/WB copy
wb_data_out  out  32  writeback/forwarding value

Behaviour:
- Reset: all MA/WB outputs 0, FSM to IDLE, load buffer 0.
- dmem_address = {alu_in[31:2],2'b00}.
- dmem_mbe = mem_byte_enable_in.
- dmem_wdata = rs2_in << (8*alu_in[1:0]).
- FSM states: IDLE, WAIT, HOLD. mem_op = ctrl_word_in.mem_read | mem_write.
- IDLE/WAIT:
  - dmem_read = mem_read, dmem_write = mem_write (combinational from the current EX/MA contents).
  - MA_stall = mem_op & !dmem_resp.
  - IDLE→WAIT when mem_op & !dmem_resp. WAIT stays until dmem_resp.
- On dmem_resp with IF_stall=1: latch dmem_rdata into the load buffer, go HOLD.
- HOLD:
  - Requests deasserted; MA_stall=0.
  - Load data taken from the buffer; dmem_resp ignored.
  - →IDLE when the register advances.
- Register advance: when !MA_stall & !IF_stall, the MA/WB register captures the stage inputs and wb_data_out; otherwise it holds.
  - 0-cycle added latency for non-memory ops.
  - Memory ops: N+1 cycles, where N is the number of cycles to dmem_resp.
- A resp arriving in the same cycle as the request gives no stall.
- Load extraction: s = source data >> (8*alu_in[1:0]).
  - lb: sign-extend s[7:0]; lbu: zero-extend s[7:0].
  - lh: sign-extend s[15:0]; lhu: zero-extend s[15:0].
  - lw: s (misaligned lw returns zero-filled upper bytes; no trap).
- wb_data_out selection, first match:
  - load → extracted load data
  - jal/jalr → PC_in+4
  - op_imm/op_reg with funct3 010/011 → {31'b0, br_en_in}
  - otherwise → alu_in
- Boundaries:
  - rst in WAIT/HOLD → IDLE; buffer cleared; request drops the cycle after rst.
  - dmem_resp in IDLE with no mem_op is ignored.
  - Stores produce no wb_data change beyond alu_in.
  - A bubble (ctrl 0) passes with no request.

Optional Feature:
- Macro: MA_PERF_CNT_EN.
- Defined:
  - Adds outputs ma_stall_cycles[31:0] (increments each cycle MA_stall=1).
  - Adds ma_mem_ops[31:0] (increments on each accepted dmem_resp in IDLE/WAIT).
  - Both clear on rst and wrap at 2^32.
- Undefined: ports absent, no counters.

Decomposition:
- Package ma_types: ma_state_t enum {IDLE, WAIT, HOLD}; SLT/SLTU funct3 constants. Reuse load_funct3_t and the opcodes from rv32i_types.
- Sub-module load_align (combinational): inputs rdata, offset[1:0], funct3; output 32-bit extracted data.

Test Plan:
- lb, alu_in=0x1003, dmem_rdata=0x80112233, resp after 2 cycles:
  - MA_stall high 2 cycles.
  - wb_data_out=0xFFFFFF80, dmem_address=0x1000.
- sh, alu_in=0x2002, rs2_in=0x0000ABCD, mbe 1100:
  - dmem_write=1, dmem_wdata=0xABCD0000, dmem_mbe=1100.
  - Completes on resp.
- lhu, offset 2, rdata=0x9ABC0000, resp arrives with IF_stall=1 for 3 cycles:
  - FSM enters HOLD; no re-request.
  - After IF_stall drops, wb_data_out=0x00009ABC.
- jal, PC_in=0x40 → wb_data_out=0x44, zero stall. slti with br_en_in=1 → wb_data_out=1.
- rst asserted in WAIT:
  - Next cycle all outputs 0, requests low.
  - A stray dmem_resp after reset is ignored.
- MA_PERF_CNT_EN: two loads with 3-cycle latency → ma_stall_cycles=4, ma_mem_ops=2 (each load stalls 2 cycles, resp cycle not stalled).
